// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters, with a
// one-entry response buffer and per-requester flags. Optional macro: ALU_ARB_TIMEOUT_EN.
module alu_arbiter #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [4:0]       alu_flags,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic [4:0]       rsp_flags,
    output logic [4:0]       flags0,
    output logic [4:0]       flags1,
    output logic             busy,
    output logic             timeout_err
);

    localparam int unsigned OP_W   = 3;
    localparam int unsigned FLAG_W = 5;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t            state, state_nxt;
    logic              last_grant;
    logic              id_q;
    logic [OP_W-1:0]   op_q;
    logic              grant0_c, grant1_c, accept_c, hs_c;
    logic [WIDTH-1:0]  sel_a_c, sel_b_c;
    logic [OP_W-1:0]   sel_op_c;
    logic              sel_illegal_c, op_illegal_c, flag_upd_c, expire_c;

`ifdef ALU_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [CNT_W-1:0] wait_cnt;
`endif

    // Round-robin grant: on a tie the requester that did not win last time goes first.
    always_comb begin
        grant0_c      = req0_valid && (!req1_valid || last_grant);
        grant1_c      = req1_valid && (!req0_valid || !last_grant);
        req0_ready    = (state == IDLE) && grant0_c;
        req1_ready    = (state == IDLE) && grant1_c;
        accept_c      = req0_ready || req1_ready;
        hs_c          = (state == RESP) && rsp_ready;
        sel_a_c       = req1_ready ? req1_a  : req0_a;
        sel_b_c       = req1_ready ? req1_b  : req0_b;
        sel_op_c      = req1_ready ? req1_op : req0_op;
        sel_illegal_c = (sel_op_c[2:1] == 2'b11);
        op_illegal_c  = (op_q[2:1] == 2'b11);
        // ld/st, mov and branch leave the architectural flags alone.
        flag_upd_c    = !((op_q == 3'b011) || (op_q == 3'b100) || (op_q == 3'b101));
`ifdef ALU_ARB_TIMEOUT_EN
        expire_c      = (state == RESP) && !rsp_ready && (wait_cnt == CNT_W'(TIMEOUT - 1));
`else
        expire_c      = 1'b0;
`endif
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept_c) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (hs_c || expire_c) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            id_q       <= 1'b0;
            op_q       <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_ctrl   <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_flags  <= '0;
            flags0     <= '0;
            flags1     <= '0;
            busy       <= 1'b0;
`ifdef ALU_ARB_TIMEOUT_EN
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != IDLE);
`ifdef ALU_ARB_TIMEOUT_EN
            timeout_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        id_q       <= req1_ready;
                        last_grant <= req1_ready;
                        alu_a      <= sel_a_c;
                        alu_b      <= sel_b_c;
                        op_q       <= sel_op_c;
                        if (!sel_illegal_c) alu_ctrl <= sel_op_c;
                    end
                end
                EXEC: begin
                    rsp_valid <= 1'b1;
                    rsp_id    <= id_q;
                    if (op_illegal_c) begin
                        rsp_result <= '0;
                        rsp_flags  <= FLAG_W'(5'b10000);
                    end else begin
                        rsp_result <= alu_result;
                        rsp_flags  <= alu_flags;
                    end
`ifdef ALU_ARB_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                end
                RESP: begin
                    if (hs_c) begin
                        rsp_valid <= 1'b0;
                        if (flag_upd_c) begin
                            if (rsp_id) flags1 <= rsp_flags;
                            else        flags0 <= rsp_flags;
                        end
                    end
`ifdef ALU_ARB_TIMEOUT_EN
                    else if (expire_c) begin
                        rsp_valid   <= 1'b0;
                        timeout_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
`endif
                end
                default: ;
            endcase
        end
    end

`ifndef ALU_ARB_TIMEOUT_EN
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: vector table plus hand-written corner sequences,
// with a scoreboard queue fed at request accept and drained at response handshake.
module tb_alu_arbiter;

    localparam int unsigned W       = 16;
    localparam int unsigned TIMEOUT = 15;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0_valid, req0_ready, req1_valid, req1_ready;
    logic [W-1:0]  req0_a, req0_b, req1_a, req1_b;
    logic [2:0]    req0_op, req1_op;
    logic [W-1:0]  alu_a, alu_b, alu_result;
    logic [2:0]    alu_ctrl;
    logic [4:0]    alu_flags;
    logic          rsp_valid, rsp_ready, rsp_id;
    logic [W-1:0]  rsp_result;
    logic [4:0]    rsp_flags, flags0, flags1;
    logic          busy, timeout_err;

    alu_arbiter #(.WIDTH(W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_result(alu_result), .alu_flags(alu_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
        .rsp_flags(rsp_flags), .flags0(flags0), .flags1(flags1), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       id;
        logic [2:0] op;
        logic [15:0] a, b, result;
        logic [4:0] flags;
        int         acc_cyc;
    } sb_t;

    typedef struct {
        logic       id;
        logic [2:0] op;
        logic [15:0] a, b, exp_result;
        logic [4:0] exp_flags, exp_freg;
    } vec_t;

    sb_t         sb[$];
    logic        grant_log[$];
    int          n_checks = 0, n_fail = 0, cyc = 0;
    logic [4:0]  m_flags0 = '0, m_flags1 = '0;
    logic [15:0] last_rsp_result;
    logic [4:0]  last_rsp_flags;
    logic        last_rsp_id;
    bit          alu_chk = 0, lat_seen = 0;
    int          n_timeouts = 0;

    // Reference ALU: {result[15:0], E, N, Z, C, V}; illegal opcodes give the error response.
    function automatic logic [20:0] alu_fn(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        logic [15:0] r;
        logic        c, v;
        s = '0; r = '0; c = 1'b0; v = 1'b0;
        case (op)
            3'b000, 3'b011, 3'b101: begin
                s = {1'b0, a} + {1'b0, b}; r = s[15:0]; c = s[16];
                v = (a[15] == b[15]) && (r[15] != a[15]);
            end
            3'b001: begin
                s = {1'b0, a} + 17'd1; r = s[15:0]; c = s[16];
                v = !a[15] && r[15];
            end
            3'b010: begin
                s = {1'b0, a} + {1'b0, ~b} + 17'd1; r = s[15:0]; c = s[16];
                v = (a[15] != b[15]) && (r[15] != a[15]);
            end
            3'b100: r = a;
            default: return {16'h0000, 5'b10000};
        endcase
        return {r, 1'b0, r[15], (r == 16'h0000), c, v};
    endfunction

    function automatic bit upd(input logic [2:0] op);
        return !((op == 3'b011) || (op == 3'b100) || (op == 3'b101));
    endfunction

    always_comb {alu_result, alu_flags} = alu_fn(alu_ctrl, alu_a, alu_b);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: scoreboard push on accept, compare/pop on response, flag and handshake invariants.
    always @(negedge clk) begin
        if (rst_n) begin
            sb_t e;
            logic [20:0] x;
            chk("flags0", 32'(flags0), 32'(m_flags0));
            chk("flags1", 32'(flags1), 32'(m_flags1));
            chk("ready_both", 32'(req0_ready && req1_ready), 32'd0);
            if (busy) chk("ready_while_busy", 32'({req0_ready, req1_ready}), 32'd0);
`ifndef ALU_ARB_TIMEOUT_EN
            chk("timeout_err", 32'(timeout_err), 32'd0);
`endif
            if (alu_chk) begin
                alu_chk = 0;
                e = sb[$];
                chk("alu_a", 32'(alu_a), 32'(e.a));
                chk("alu_b", 32'(alu_b), 32'(e.b));
                if (e.op[2:1] != 2'b11) chk("alu_ctrl", 32'(alu_ctrl), 32'(e.op));
            end
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL rsp_unexpected: got rsp_valid=1 expected no response (cycle %0d)", cyc);
                end else begin
                    e = sb[0];
                    chk("rsp_id", 32'(rsp_id), 32'(e.id));
                    chk("rsp_result", 32'(rsp_result), 32'(e.result));
                    chk("rsp_flags", 32'(rsp_flags), 32'(e.flags));
                    if (!lat_seen) begin
                        lat_seen = 1;
                        chk("latency", 32'(cyc - e.acc_cyc), 32'd2);
                    end
                    if (rsp_ready) begin
                        last_rsp_result = rsp_result;
                        last_rsp_flags  = rsp_flags;
                        last_rsp_id     = rsp_id;
                        void'(sb.pop_front());
                        if (upd(e.op)) begin
                            if (e.id) m_flags1 = e.flags;
                            else      m_flags0 = e.flags;
                        end
                    end
                end
            end
`ifdef ALU_ARB_TIMEOUT_EN
            if (timeout_err) begin
                n_timeouts++;
                if (sb.size() > 0) void'(sb.pop_front());
            end
`endif
            if (req0_valid && req0_ready) begin
                x = alu_fn(req0_op, req0_a, req0_b);
                sb.push_back('{1'b0, req0_op, req0_a, req0_b, x[20:5], x[4:0], cyc});
                grant_log.push_back(1'b0);
                alu_chk = 1; lat_seen = 0;
            end
            if (req1_valid && req1_ready) begin
                x = alu_fn(req1_op, req1_a, req1_b);
                sb.push_back('{1'b1, req1_op, req1_a, req1_b, x[20:5], x[4:0], cyc});
                grant_log.push_back(1'b1);
                alu_chk = 1; lat_seen = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic drive(input logic id, input logic v, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        if (id) begin req1_valid = v; req1_op = op; req1_a = a; req1_b = b; end
        else    begin req0_valid = v; req0_op = op; req0_a = a; req0_b = b; end
    endtask

    task automatic wait_ready(input logic id);
        bit ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = id ? req1_ready : req0_ready;
        end
        chk("accept_wait", 32'(ok), 32'd1);
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            ok = !busy && !rsp_valid && (sb.size() == 0);
        end
        chk("idle_wait", 32'(ok), 32'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_alu"}, 32'({alu_a, alu_b, alu_ctrl}), 32'd0);
        chk({tag, "_rsp"}, 32'({rsp_valid, rsp_id, rsp_result, rsp_flags}), 32'd0);
        chk({tag, "_flags"}, 32'({flags0, flags1}), 32'd0);
        chk({tag, "_ctl"}, 32'({busy, timeout_err, req0_ready, req1_ready}), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[9];
        vecs[0] = '{1'b0, 3'b000, 16'h0005, 16'h0003, 16'h0008, 5'b00000, 5'b00000};
        vecs[1] = '{1'b1, 3'b000, 16'h0000, 16'h0000, 16'h0000, 5'b00100, 5'b00100};
        vecs[2] = '{1'b1, 3'b100, 16'h1234, 16'h0000, 16'h1234, 5'b00000, 5'b00100};
        vecs[3] = '{1'b0, 3'b001, 16'hFFFF, 16'h0000, 16'h0000, 5'b00110, 5'b00110};
        vecs[4] = '{1'b0, 3'b010, 16'h0003, 16'h0005, 16'hFFFE, 5'b01000, 5'b01000};
        vecs[5] = '{1'b1, 3'b000, 16'h7FFF, 16'h0001, 16'h8000, 5'b01001, 5'b01001};
        vecs[6] = '{1'b1, 3'b011, 16'h0100, 16'h0020, 16'h0120, 5'b00000, 5'b01001};
        vecs[7] = '{1'b0, 3'b101, 16'h0010, 16'h0004, 16'h0014, 5'b00000, 5'b01000};
        vecs[8] = '{1'b0, 3'b100, 16'h8000, 16'h0000, 16'h8000, 5'b01000, 5'b01000};

        rst_n = 1'b0; rsp_ready = 1'b0;
        drive(1'b0, 1'b0, 3'b000, 16'h0, 16'h0);
        drive(1'b1, 1'b0, 3'b000, 16'h0, 16'h0);
        repeat (3) tick();
        chk_all_zero("reset");
        rst_n = 1'b1; rsp_ready = 1'b1;

        // Vector table, one request at a time; operands scrambled right after accept.
        foreach (vecs[i]) begin
            tick();
            drive(vecs[i].id, 1'b1, vecs[i].op, vecs[i].a, vecs[i].b);
            wait_ready(vecs[i].id);
            tick();
            drive(vecs[i].id, 1'b0, 3'($urandom), 16'($urandom), 16'($urandom));
            wait_idle();
            chk("vec_id", 32'(last_rsp_id), 32'(vecs[i].id));
            chk("vec_result", 32'(last_rsp_result), 32'(vecs[i].exp_result));
            chk("vec_flags", 32'(last_rsp_flags), 32'(vecs[i].exp_flags));
            chk("vec_freg", 32'(vecs[i].id ? flags1 : flags0), 32'(vecs[i].exp_freg));
        end

        // Illegal opcode: ALU control keeps the mov from the last vector, error response.
        tick();
        drive(1'b0, 1'b1, 3'b111, 16'hAAAA, 16'h5555);
        wait_ready(1'b0);
        tick();
        drive(1'b0, 1'b0, 3'b000, 16'h0, 16'h0);
        chk("illegal_alu_ctrl", 32'(alu_ctrl), 32'(3'b100));
        wait_idle();
        chk("illegal_result", 32'(last_rsp_result), 32'h0);
        chk("illegal_flags", 32'(last_rsp_flags), 32'(5'b10000));
        chk("illegal_freg", 32'(flags0), 32'(5'b10000));

        // Consumer stall: response holds, no grants while req1 waits, then req1 wins in IDLE.
        tick();
        rsp_ready = 1'b0;
        drive(1'b0, 1'b1, 3'b000, 16'h0001, 16'h0002);
        wait_ready(1'b0);
        tick();
        drive(1'b0, 1'b0, 3'b000, 16'h0, 16'h0);
        drive(1'b1, 1'b1, 3'b100, 16'h0055, 16'h0000);
        repeat (2) @(negedge clk);
        repeat (6) begin
            @(negedge clk);
            chk("stall_busy", 32'(busy), 32'd1);
            chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
        end
        tick();
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("stall_release_busy", 32'(busy), 32'd0);
        chk("stall_release_grant", 32'(req1_ready), 32'd1);
        tick();
        drive(1'b1, 1'b0, 3'b000, 16'h0, 16'h0);
        wait_idle();

        // Reset while in EXEC: everything clears at once, response is lost.
        tick();
        drive(1'b1, 1'b1, 3'b000, 16'h0009, 16'h0009);
        wait_ready(1'b1);
        tick();
        drive(1'b1, 1'b0, 3'b000, 16'h0, 16'h0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        sb.delete(); grant_log.delete();
        m_flags0 = '0; m_flags1 = '0; alu_chk = 0; lat_seen = 0;
        repeat (2) tick();
        rst_n = 1'b1;

        // Both held valid from reset: requester 0 first, then strict alternation.
        tick();
        drive(1'b0, 1'b1, 3'b000, 16'($urandom), 16'($urandom));
        drive(1'b1, 1'b1, 3'b000, 16'($urandom), 16'($urandom));
        @(negedge clk);
        chk("tie_req0_ready", 32'(req0_ready), 32'd1);
        chk("tie_req1_ready", 32'(req1_ready), 32'd0);
        tick();
        for (int c = 0; c < 60 && grant_log.size() < 4; c++) begin
            drive(1'b0, 1'b1, 3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom));
            drive(1'b1, 1'b1, 3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom));
            tick();
        end
        drive(1'b0, 1'b0, 3'b000, 16'h0, 16'h0);
        drive(1'b1, 1'b0, 3'b000, 16'h0, 16'h0);
        chk("alt_count", 32'(grant_log.size() >= 4), 32'd1);
        for (int i = 0; i < 4 && i < grant_log.size(); i++)
            chk("alt_order", 32'(grant_log[i]), 32'(i % 2));
        wait_idle();

`ifdef ALU_ARB_TIMEOUT_EN
        begin
            int  resp_cycles = 0;
            bit  seen = 0;
            tick();
            rsp_ready = 1'b0;
            drive(1'b1, 1'b1, 3'b000, 16'h0010, 16'h0020);
            wait_ready(1'b1);
            tick();
            drive(1'b1, 1'b0, 3'b000, 16'h0, 16'h0);
            for (int i = 0; i < 40 && !seen; i++) begin
                @(negedge clk);
                if (timeout_err) seen = 1;
                else if (rsp_valid) resp_cycles++;
            end
            chk("timeout_seen", 32'(seen), 32'd1);
            chk("timeout_cycles", 32'(resp_cycles), 32'(TIMEOUT));
            @(negedge clk);
            chk("timeout_pulse", 32'(timeout_err), 32'd0);
            chk("timeout_rsp_valid", 32'(rsp_valid), 32'd0);
            tick();
            rsp_ready = 1'b1;
            wait_idle();
            chk("timeout_count", 32'(n_timeouts), 32'd1);
        end
`endif

        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
